branch_resolver: RTL and testbench

- Client-side controller for the 2-bit branch predictor; it sits between the fetch/execute pipeline and the predictor.
- Forwards fetch-time prediction requests to the predictor and captures the returned prediction bit.
- Queues captured predictions in order until each branch resolves, then reports the actual outcome back to the predictor (result/taken).
- Flags mispredictions and keeps saturating hit/miss statistics.

---
 rtl/branch_resolver_if.sv | 33 +++
 rtl/branch_resolver.sv | 93 +++++++++
 tb/tb_branch_resolver.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/branch_resolver_if.sv
// Bundle of pipeline, predictor and statistics signals around the branch resolver.
// The resolver uses the slave modport; the pipeline/predictor side uses master.
interface branch_resolver_if #(
   parameter int CNT_W = 16
);
   logic             fetch_valid;
   logic             fetch_ready;
   logic             fetch_pred_valid;
   logic             fetch_pred;
   logic             resolve_valid;
   logic             resolve_taken;
   logic             mispredict;
   logic             flush;
   logic             request;
   logic             prediction;
   logic             result;
   logic             taken;
   logic [CNT_W-1:0] hit_count;
   logic [CNT_W-1:0] miss_count;
   logic             underflow_err;

   modport master (
      output fetch_valid, resolve_valid, resolve_taken, flush, prediction,
      input  fetch_ready, fetch_pred_valid, fetch_pred, mispredict, request,
             result, taken, hit_count, miss_count, underflow_err
   );

   modport slave (
      input  fetch_valid, resolve_valid, resolve_taken, flush, prediction,
      output fetch_ready, fetch_pred_valid, fetch_pred, mispredict, request,
             result, taken, hit_count, miss_count, underflow_err
   );
endinterface

// File: rtl/branch_resolver.sv
// Client-side controller for a 2-bit branch predictor: requests predictions at fetch,
// holds them in order until resolve, reports outcomes and keeps hit/miss statistics.
module branch_resolver #(
   parameter int DEPTH = 4,
   parameter int CNT_W = 16
) (
   input logic              clk,
   input logic              rst,
   branch_resolver_if.slave bus
);
   localparam int             PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W:0] DEPTH_L = (PTR_W+1)'(DEPTH);

   logic             fifo_p1 [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;
   logic [PTR_W:0]   occ;
   logic             vld_p1;
   logic [CNT_W-1:0] hit_q;
   logic [CNT_W-1:0] miss_q;
   logic             uf_q;

   logic             accept_p0;
   logic             push_p1;
   logic             pop;
   logic             miss_now;
   logic             resolve_empty;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   // Stage p0: fetch accept and request to the predictor
   always_comb begin
      occ              = count + (PTR_W+1)'(vld_p1);
      bus.fetch_ready  = (occ < DEPTH_L) && !bus.flush;
      accept_p0        = bus.fetch_valid && bus.fetch_ready && !rst;
      bus.request      = accept_p0;
   end

   // Stage p1: prediction capture; a flush discards the returning bit
   always_comb begin
      push_p1              = vld_p1 && !bus.flush && !rst;
      bus.fetch_pred_valid = push_p1;
      bus.fetch_pred       = push_p1 && bus.prediction;
   end

   // Resolve: only entries already stored are resolvable, not a same-cycle capture
   always_comb begin
      pop            = bus.resolve_valid && (count != '0) && !bus.flush && !rst;
      resolve_empty  = bus.resolve_valid && (count == '0) && !bus.flush;
      miss_now       = pop && (fifo_p1[rd_ptr] != bus.resolve_taken);
      bus.result     = pop;
      bus.taken      = pop && bus.resolve_taken;
      bus.mispredict = miss_now;
      bus.hit_count     = hit_q;
      bus.miss_count    = miss_q;
      bus.underflow_err = uf_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         vld_p1 <= 1'b0;
         hit_q  <= '0;
         miss_q <= '0;
         uf_q   <= 1'b0;
      end else if (bus.flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         vld_p1 <= 1'b0;
      end else begin
         vld_p1 <= accept_p0;
         if (push_p1) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
            if (miss_now) miss_q <= sat_inc(miss_q);
            else          hit_q  <= sat_inc(hit_q);
         end
         count <= count + (PTR_W+1)'(push_p1) - (PTR_W+1)'(pop);
         if (resolve_empty) uf_q <= 1'b1;
      end
   end

   // Prediction storage carries no reset; occupancy is tracked by count
   always_ff @(posedge clk) begin
      if (push_p1) fifo_p1[wr_ptr] <= bus.prediction;
   end
endmodule

// File: tb/tb_branch_resolver.sv
// Scoreboard bench for branch_resolver: a queue-based reference model predicts each
// cycle's responses; a monitor compares whenever the DUT presents them.
module tb_branch_resolver;
   localparam int DEPTH = 4;

   typedef struct {
      logic skip;
      logic ready;
      logic request;
      logic result;
      logic uf;
      int   hit16;
      int   miss16;
      int   hit2;
      int   miss2;
   } stat_t;

   typedef struct {
      logic taken;
      logic misp;
   } res_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   branch_resolver_if #(.CNT_W(16)) bi();
   branch_resolver_if #(.CNT_W(2))  bs();

   branch_resolver #(.DEPTH(DEPTH), .CNT_W(16)) dut     (.clk(clk), .rst(rst), .bus(bi.slave));
   branch_resolver #(.DEPTH(DEPTH), .CNT_W(2))  dut_sat (.clk(clk), .rst(rst), .bus(bs.slave));

   always #5 clk = ~clk;

   stat_t stat_q[$];
   logic  pred_q[$];
   res_t  res_q[$];

   // reference model state: outstanding predictions, pending flag, statistics
   logic  mq[$];
   logic  pend = 1'b0;
   int    hits = 0;
   int    misses = 0;
   logic  uf = 1'b0;

   int n_cmp = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int sat(input int v, input int w);
      int m;
      m = (1 << w) - 1;
      return (v > m) ? m : v;
   endfunction

   function automatic logic rb(input int pct);
      return ($urandom_range(99) < pct);
   endfunction

   task automatic drive(input logic fv, input logic rv, input logic rt, input logic fl, input logic pr);
      bi.fetch_valid = fv; bs.fetch_valid = fv;
      bi.resolve_valid = rv; bs.resolve_valid = rv;
      bi.resolve_taken = rt; bs.resolve_taken = rt;
      bi.flush = fl; bs.flush = fl;
      bi.prediction = pr; bs.prediction = pr;
   endtask

   // One clock cycle: apply inputs, queue expectations, advance the model, cross the edge.
   task automatic step(input logic fv, input logic rv, input logic rt, input logic fl,
                       input logic pr, input logic r);
      stat_t s;
      res_t  e;
      int    sz;
      logic  acc;
      logic  cap;
      logic  res;
      rst = r;
      drive(fv, rv, rt, fl, pr);
      sz = mq.size();
      s.skip    = r;
      s.ready   = ((sz + int'(pend)) < DEPTH) && !fl;
      acc       = fv && s.ready && !r;
      cap       = pend && !fl && !r;
      res       = rv && (sz > 0) && !fl && !r;
      s.request = acc;
      s.result  = res;
      s.uf      = uf;
      s.hit16   = sat(hits, 16);
      s.miss16  = sat(misses, 16);
      s.hit2    = sat(hits, 2);
      s.miss2   = sat(misses, 2);
      e.taken   = rt;
      e.misp    = 1'b0;
      if (cap) pred_q.push_back(pr);
      if (res) begin
         e.misp = (mq[0] != rt);
         res_q.push_back(e);
      end
      stat_q.push_back(s);
      if (r) begin
         mq.delete(); pend = 1'b0; hits = 0; misses = 0; uf = 1'b0;
      end else if (fl) begin
         mq.delete(); pend = 1'b0;
      end else begin
         if (res) begin
            if (e.misp) misses++;
            else        hits++;
            void'(mq.pop_front());
         end
         if (rv && sz == 0) uf = 1'b1;
         if (cap) mq.push_back(pr);
         pend = acc;
      end
      @(posedge clk);
      #1;
   endtask

   // monitor
   initial begin
      stat_t s;
      res_t  e;
      forever begin
         @(negedge clk);
         if (stat_q.size() > 0) begin
            s = stat_q.pop_front();
            if (!s.skip) begin
               chk("fetch_ready", 32'(bi.fetch_ready), 32'(s.ready));
               chk("request", 32'(bi.request), 32'(s.request));
               chk("result", 32'(bi.result), 32'(s.result));
               chk("hit_count", 32'(bi.hit_count), s.hit16);
               chk("miss_count", 32'(bi.miss_count), s.miss16);
               chk("underflow_err", 32'(bi.underflow_err), 32'(s.uf));
               chk("hit_count_sat", 32'(bs.hit_count), s.hit2);
               chk("miss_count_sat", 32'(bs.miss_count), s.miss2);
               if (!s.result) begin
                  chk("taken_idle", 32'(bi.taken), 32'd0);
                  chk("mispredict_idle", 32'(bi.mispredict), 32'd0);
               end
            end
         end
         if (bi.fetch_pred_valid === 1'b1) begin
            if (pred_q.size() == 0) chk("fetch_pred_valid_unexpected", 32'(bi.fetch_pred_valid), 32'd0);
            else chk("fetch_pred", 32'(bi.fetch_pred), 32'(pred_q.pop_front()));
         end
         if (bi.result === 1'b1 && res_q.size() > 0) begin
            e = res_q.pop_front();
            chk("taken", 32'(bi.taken), 32'(e.taken));
            chk("mispredict", 32'(bi.mispredict), 32'(e.misp));
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic p3 [7];
      p3 = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      repeat (3) @(posedge clk);
      #1;

      // single branch, predicted taken, resolved not taken
      step(1, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0);

      // back-to-back fetches until full, then in-order resolves
      for (int i = 0; i < 6; i++) step(1, 0, 0, 0, p3[i], 0);
      step(0, 1, 1, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0);
      step(0, 1, 1, 0, 0, 0);
      step(0, 1, 1, 0, 0, 0);

      // concurrent push and pop with pointer wrap
      for (int c = 0; c < 12; c++) step(c < 10, c >= 2, rb(50), 0, rb(50), 0);

      // flush with a capture in flight, then a resolve with nothing outstanding
      step(1, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 1, 0);
      step(1, 0, 0, 0, 0, 0);
      step(0, 1, 1, 1, 1, 0);
      step(0, 0, 0, 0, 1, 0);
      step(0, 1, 0, 0, 0, 0);

      // reset mid-stream with three entries queued
      step(1, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 1, 0);
      step(1, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 1, 0);
      step(1, 1, 1, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0);

      // randomized traffic
      for (int c = 0; c < 500; c++)
         step(rb(65), rb(45), rb(50), rb(4), rb(50), rb(1));

      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      #1;
      chk("pred_q_drained", pred_q.size(), 32'd0);
      chk("res_q_drained", res_q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
